// File: rtl/imm_gen_stage_pkg.sv
// Shared opcode constants, immediate format codes and skid-buffer state encodings
// for the immediate-generation stage.
package imm_gen_stage_pkg;

  localparam logic [6:0] OPCODE_LOAD      = 7'b0000011;
  localparam logic [6:0] OPCODE_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPCODE_FENCE     = OPCODE_MISC_MEM;
  localparam logic [6:0] OPCODE_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPCODE_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPCODE_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPCODE_STORE     = 7'b0100011;
  localparam logic [6:0] OPCODE_OP        = 7'b0110011;
  localparam logic [6:0] OPCODE_LUI       = 7'b0110111;
  localparam logic [6:0] OPCODE_OP_32     = 7'b0111011;
  localparam logic [6:0] OPCODE_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPCODE_JALR      = 7'b1100111;
  localparam logic [6:0] OPCODE_JAL       = 7'b1101111;
  localparam logic [6:0] OPCODE_SYSTEM    = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_FMT_NONE  = 3'd0,
    IMM_FMT_I     = 3'd1,
    IMM_FMT_S     = 3'd2,
    IMM_FMT_B     = 3'd3,
    IMM_FMT_U     = 3'd4,
    IMM_FMT_J     = 3'd5,
    IMM_FMT_CSR   = 3'd6,
    IMM_FMT_SHAMT = 3'd7
  } imm_fmt_e;

  // Skid-buffer occupancy states
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  function automatic logic is_shift_f3(input logic [2:0] f3);
    return (f3 == 3'b001) || (f3 == 3'b101);
  endfunction

endpackage

// File: rtl/imm_gen_stage_if.sv
// Instruction-in / immediate-out handshake bundle for imm_gen_stage.
interface imm_gen_stage_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_inst;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [2:0]       out_fmt;
  logic             out_unknown;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_inst, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_unknown, out_tag
  );

  modport slave (
    input  in_valid, in_inst, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_unknown, out_tag
  );
endinterface

// File: rtl/imm_gen_stage_decode.sv
// Combinational RISC-V immediate decoder: instruction word to immediate,
// format code and unknown-opcode flag.
module imm_decode
  import imm_gen_stage_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter bit          EN_CSR   = 1'b1,
  parameter bit          EN_SHAMT = 1'b1
) (
  input  logic [31:0]     inst_i,
  output logic [XLEN-1:0] imm_o,
  output imm_fmt_e        fmt_o,
  output logic            unknown_o
);

  localparam bit RV64 = (XLEN == 64);

  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [XLEN-1:0] shamt5, shamt6, zimm;

  assign opcode = inst_i[6:0];
  assign f3     = inst_i[14:12];

  assign imm_i  = {{(XLEN-12){inst_i[31]}}, inst_i[31:20]};
  assign imm_s  = {{(XLEN-12){inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
  assign imm_b  = {{(XLEN-12){inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign imm_u  = {{(XLEN-31){inst_i[31]}}, inst_i[30:12], 12'b0};
  assign imm_j  = {{(XLEN-20){inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
  assign shamt5 = XLEN'(inst_i[24:20]);
  assign shamt6 = XLEN'(inst_i[25:20]);
  assign zimm   = XLEN'(inst_i[19:15]);

  always_comb begin
    imm_o     = '0;
    fmt_o     = IMM_FMT_NONE;
    unknown_o = 1'b0;
    case (opcode)
      OPCODE_OP_IMM: begin
        if (EN_SHAMT && is_shift_f3(f3)) begin
          fmt_o = IMM_FMT_SHAMT;
          imm_o = RV64 ? shamt6 : shamt5;
        end else begin
          fmt_o = IMM_FMT_I;
          imm_o = imm_i;
        end
      end
      // Word-sized ops only exist on RV64; addiw and friends use the I format.
      OPCODE_OP_IMM_32: begin
        if (!RV64) begin
          unknown_o = 1'b1;
        end else if (EN_SHAMT && is_shift_f3(f3)) begin
          fmt_o = IMM_FMT_SHAMT;
          imm_o = shamt5;
        end else begin
          fmt_o = IMM_FMT_I;
          imm_o = imm_i;
        end
      end
      OPCODE_LOAD, OPCODE_JALR, OPCODE_MISC_MEM: begin
        fmt_o = IMM_FMT_I;
        imm_o = imm_i;
      end
      OPCODE_STORE: begin
        fmt_o = IMM_FMT_S;
        imm_o = imm_s;
      end
      OPCODE_BRANCH: begin
        fmt_o = IMM_FMT_B;
        imm_o = imm_b;
      end
      OPCODE_LUI, OPCODE_AUIPC: begin
        fmt_o = IMM_FMT_U;
        imm_o = imm_u;
      end
      OPCODE_JAL: begin
        fmt_o = IMM_FMT_J;
        imm_o = imm_j;
      end
      OPCODE_OP: ;
      OPCODE_OP_32: unknown_o = !RV64;
      OPCODE_SYSTEM: begin
        if (EN_CSR && f3[2]) begin
          fmt_o = IMM_FMT_CSR;
          imm_o = zimm;
        end
      end
      default: unknown_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage: decoder followed by a 2-entry FIFO skid
// buffer whose in_ready is a register, so out_ready never reaches it combinationally.
module imm_gen_stage
  import imm_gen_stage_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned TAG_W    = 32,
  parameter bit          EN_CSR   = 1'b1,
  parameter bit          EN_SHAMT = 1'b1
) (
  input logic             clk,
  input logic             rst_n,
  input logic             flush,
  imm_gen_stage_if.slave  bus
);

  logic [XLEN-1:0] dec_imm;
  imm_fmt_e        dec_fmt;
  logic            dec_unk;

  imm_decode #(
    .XLEN     (XLEN),
    .EN_CSR   (EN_CSR),
    .EN_SHAMT (EN_SHAMT)
  ) u_dec (
    .inst_i    (bus.in_inst),
    .imm_o     (dec_imm),
    .fmt_o     (dec_fmt),
    .unknown_o (dec_unk)
  );

  logic [1:0]       state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic [XLEN-1:0]  out_imm_q, out_imm_d, skd_imm_q, skd_imm_d;
  logic [2:0]       out_fmt_q, out_fmt_d, skd_fmt_q, skd_fmt_d;
  logic             out_unk_q, out_unk_d, skd_unk_q, skd_unk_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d, skd_tag_q, skd_tag_d;
  logic             accept;

  // in_ready_q is low only in TWO, so no acceptance can occur there.
  assign accept = bus.in_valid && in_ready_q;

  always_comb begin
    state_d   = state_q;
    out_imm_d = out_imm_q;
    out_fmt_d = out_fmt_q;
    out_unk_d = out_unk_q;
    out_tag_d = out_tag_q;
    skd_imm_d = skd_imm_q;
    skd_fmt_d = skd_fmt_q;
    skd_unk_d = skd_unk_q;
    skd_tag_d = skd_tag_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          out_imm_d = dec_imm;
          out_fmt_d = dec_fmt;
          out_unk_d = dec_unk;
          out_tag_d = bus.in_tag;
          state_d   = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && bus.out_ready) begin
          out_imm_d = dec_imm;
          out_fmt_d = dec_fmt;
          out_unk_d = dec_unk;
          out_tag_d = bus.in_tag;
        end else if (accept) begin
          skd_imm_d = dec_imm;
          skd_fmt_d = dec_fmt;
          skd_unk_d = dec_unk;
          skd_tag_d = bus.in_tag;
          state_d   = ST_TWO;
        end else if (bus.out_ready) begin
          state_d   = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (bus.out_ready) begin
          out_imm_d = skd_imm_q;
          out_fmt_d = skd_fmt_q;
          out_unk_d = skd_unk_q;
          out_tag_d = skd_tag_q;
          state_d   = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) begin
      state_d = ST_EMPTY;
    end
    in_ready_d = (state_d != ST_TWO);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b0;
      out_imm_q  <= '0;
      out_fmt_q  <= '0;
      out_unk_q  <= 1'b0;
      out_tag_q  <= '0;
      skd_imm_q  <= '0;
      skd_fmt_q  <= '0;
      skd_unk_q  <= 1'b0;
      skd_tag_q  <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      out_imm_q  <= out_imm_d;
      out_fmt_q  <= out_fmt_d;
      out_unk_q  <= out_unk_d;
      out_tag_q  <= out_tag_d;
      skd_imm_q  <= skd_imm_d;
      skd_fmt_q  <= skd_fmt_d;
      skd_unk_q  <= skd_unk_d;
      skd_tag_q  <= skd_tag_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = (state_q != ST_EMPTY);
  assign bus.out_imm     = out_imm_q;
  assign bus.out_fmt     = out_fmt_q;
  assign bus.out_unknown = out_unk_q;
  assign bus.out_tag     = out_tag_q;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: three configurations driven in lockstep and compared
// every cycle against a queue-based reference model.
module tb_imm_gen_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] in_inst, in_tag;

  imm_gen_stage_if #(.XLEN(32), .TAG_W(32)) bus32  ();
  imm_gen_stage_if #(.XLEN(64), .TAG_W(32)) bus64  ();
  imm_gen_stage_if #(.XLEN(32), .TAG_W(32)) busmin ();

  assign bus32.in_valid   = in_valid;
  assign bus32.in_inst    = in_inst;
  assign bus32.in_tag     = in_tag;
  assign bus32.out_ready  = out_ready;
  assign bus64.in_valid   = in_valid;
  assign bus64.in_inst    = in_inst;
  assign bus64.in_tag     = in_tag;
  assign bus64.out_ready  = out_ready;
  assign busmin.in_valid  = in_valid;
  assign busmin.in_inst   = in_inst;
  assign busmin.in_tag    = in_tag;
  assign busmin.out_ready = out_ready;

  imm_gen_stage #(.XLEN(32), .TAG_W(32), .EN_CSR(1'b1), .EN_SHAMT(1'b1)) u_rv32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus32));
  imm_gen_stage #(.XLEN(64), .TAG_W(32), .EN_CSR(1'b1), .EN_SHAMT(1'b1)) u_rv64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus64));
  imm_gen_stage #(.XLEN(32), .TAG_W(32), .EN_CSR(1'b0), .EN_SHAMT(1'b0)) u_min (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(busmin));

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference decoder built from field arithmetic on a sign-extended word.
  function automatic void ref_dec(input logic [31:0] inst, input int xlen, input bit en_csr,
                                  input bit en_sh, output logic [63:0] imm,
                                  output logic [2:0] fmt, output bit unk);
    longint s, s12, s20, s25, s31;
    logic [63:0] w;
    logic [2:0]  f3;
    bit          sh;
    s   = $signed(inst);
    s12 = s >>> 12;
    s20 = s >>> 20;
    s25 = s >>> 25;
    s31 = s >>> 31;
    w   = 64'(inst);
    f3  = inst[14:12];
    sh  = en_sh && (f3 == 3'd1 || f3 == 3'd5);
    imm = 64'd0;
    fmt = 3'd0;
    unk = 1'b0;
    case (inst[6:0])
      7'h13: if (sh) begin fmt = 3'd7; imm = (w >> 20) & ((xlen == 64) ? 64'd63 : 64'd31); end
             else begin fmt = 3'd1; imm = s20; end
      7'h1B: if (xlen != 64) unk = 1'b1;
             else if (sh) begin fmt = 3'd7; imm = (w >> 20) & 64'd31; end
             else begin fmt = 3'd1; imm = s20; end
      7'h03, 7'h67, 7'h0F: begin fmt = 3'd1; imm = s20; end
      7'h23: begin fmt = 3'd2; imm = (s25 << 5) | ((w >> 7) & 64'd31); end
      7'h63: begin
        fmt = 3'd3;
        imm = (s31 << 12) | (((w >> 7) & 64'd1) << 11) | (((w >> 25) & 64'd63) << 5)
            | (((w >> 8) & 64'd15) << 1);
      end
      7'h37, 7'h17: begin fmt = 3'd4; imm = s12 << 12; end
      7'h6F: begin
        fmt = 3'd5;
        imm = (s31 << 20) | (((w >> 12) & 64'd255) << 12) | (((w >> 20) & 64'd1) << 11)
            | (((w >> 21) & 64'd1023) << 1);
      end
      7'h33: ;
      7'h3B: unk = (xlen != 64);
      7'h73: if (en_csr && f3[2]) begin fmt = 3'd6; imm = (w >> 15) & 64'd31; end
      default: unk = 1'b1;
    endcase
    if (xlen == 32) imm[63:32] = 32'd0;
  endfunction

  typedef struct {
    logic [31:0] inst;
    logic [31:0] tag;
  } ent_t;

  ent_t q[$];
  bit   m_rdy  = 1'b0;
  bit   m_zero = 1'b1;

  task automatic check_dut(input string nm, input int xlen, input bit en_csr, input bit en_sh,
                           input logic ov, input logic ir, input logic [63:0] imm,
                           input logic [2:0] fmt, input logic unk, input logic [31:0] tag);
    logic [63:0] e_imm;
    logic [2:0]  e_fmt;
    bit          e_unk;
    check_eq({nm, ".out_valid"}, 64'(ov), 64'(q.size() > 0));
    check_eq({nm, ".in_ready"}, 64'(ir), 64'(m_rdy));
    if (q.size() > 0) begin
      ref_dec(q[0].inst, xlen, en_csr, en_sh, e_imm, e_fmt, e_unk);
      check_eq({nm, ".imm"}, imm, e_imm);
      check_eq({nm, ".fmt"}, 64'(fmt), 64'(e_fmt));
      check_eq({nm, ".unknown"}, 64'(unk), 64'(e_unk));
      check_eq({nm, ".tag"}, 64'(tag), 64'(q[0].tag));
    end else if (m_zero) begin
      check_eq({nm, ".rst_imm"}, imm, 64'd0);
      check_eq({nm, ".rst_fmt"}, 64'(fmt), 64'd0);
      check_eq({nm, ".rst_unk"}, 64'(unk), 64'd0);
      check_eq({nm, ".rst_tag"}, 64'(tag), 64'd0);
    end
  endtask

  task automatic step(input bit r, input bit f, input bit v, input logic [31:0] i,
                      input logic [31:0] t, input bit o);
    bit acc;
    rst_n = r; flush = f; in_valid = v; in_inst = i; in_tag = t; out_ready = o;
    @(posedge clk);
    if (!r) begin
      q.delete(); m_rdy = 1'b0; m_zero = 1'b1;
    end else if (f) begin
      q.delete(); m_rdy = 1'b1; m_zero = 1'b0;
    end else begin
      acc = v && m_rdy;
      if (o && q.size() > 0) void'(q.pop_front());
      if (acc) begin
        q.push_back('{inst: i, tag: t});
        m_zero = 1'b0;
      end
      m_rdy = (q.size() < 2);
    end
    @(negedge clk);
    check_dut("rv32", 32, 1'b1, 1'b1, bus32.out_valid, bus32.in_ready, 64'(bus32.out_imm),
              bus32.out_fmt, bus32.out_unknown, bus32.out_tag);
    check_dut("rv64", 64, 1'b1, 1'b1, bus64.out_valid, bus64.in_ready, bus64.out_imm,
              bus64.out_fmt, bus64.out_unknown, bus64.out_tag);
    check_dut("min", 32, 1'b0, 1'b0, busmin.out_valid, busmin.in_ready, 64'(busmin.out_imm),
              busmin.out_fmt, busmin.out_unknown, busmin.out_tag);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0]  ops [14];
    logic [31:0] w;
    ops = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h1B, 7'h23, 7'h33,
            7'h37, 7'h3B, 7'h63, 7'h67, 7'h6F, 7'h73, 7'h7F};
    w = $urandom;
    if ($urandom_range(0, 7) != 0) w[6:0] = ops[$urandom_range(0, 13)];
    return w;
  endfunction

  initial begin
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 32'h00100093, 32'hAA, 1'b1);
    check_eq("reset.in_ready", 64'(bus32.in_ready), 64'd0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    check_eq("release.in_ready", 64'(bus32.in_ready), 64'd1);

    step(1'b1, 1'b0, 1'b1, 32'hFFF00093, 32'h10, 1'b1);
    check_eq("addi.valid", 64'(bus32.out_valid), 64'd1);
    check_eq("addi.imm", 64'(bus32.out_imm), 64'h00000000FFFFFFFF);
    check_eq("addi.fmt", 64'(bus32.out_fmt), 64'd1);
    step(1'b1, 1'b0, 1'b1, 32'h0080006F, 32'h11, 1'b1);
    check_eq("jal.imm", 64'(bus32.out_imm), 64'h8);
    check_eq("jal.fmt", 64'(bus32.out_fmt), 64'd5);
    step(1'b1, 1'b0, 1'b1, 32'h3002D073, 32'h12, 1'b1);
    check_eq("csrrwi.imm", 64'(bus32.out_imm), 64'd5);
    check_eq("csrrwi.fmt", 64'(bus32.out_fmt), 64'd6);
    check_eq("csrrwi_nocsr.imm", 64'(busmin.out_imm), 64'd0);
    check_eq("csrrwi_nocsr.fmt", 64'(busmin.out_fmt), 64'd0);
    step(1'b1, 1'b0, 1'b1, 32'h00309093, 32'h13, 1'b1);
    check_eq("slli.imm", 64'(bus32.out_imm), 64'd3);
    check_eq("slli.fmt", 64'(bus32.out_fmt), 64'd7);
    step(1'b1, 1'b0, 1'b1, 32'h4030D093, 32'h14, 1'b1);
    check_eq("srai.imm", 64'(bus32.out_imm), 64'd3);
    check_eq("srai.fmt", 64'(bus32.out_fmt), 64'd7);
    step(1'b1, 1'b0, 1'b1, 32'h800000B7, 32'h15, 1'b1);
    check_eq("lui64.imm", bus64.out_imm, 64'hFFFFFFFF80000000);
    check_eq("lui64.fmt", 64'(bus64.out_fmt), 64'd4);
    step(1'b1, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h16, 1'b1);
    check_eq("op7f.unknown", 64'(bus64.out_unknown), 64'd1);
    check_eq("op7f.imm", bus64.out_imm, 64'd0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

    // Backpressure: third input must wait until the first has drained.
    step(1'b1, 1'b0, 1'b1, 32'h00100093, 32'd1, 1'b0);
    check_eq("bp.rdy1", 64'(bus32.in_ready), 64'd1);
    step(1'b1, 1'b0, 1'b1, 32'h00200093, 32'd2, 1'b0);
    check_eq("bp.rdy2", 64'(bus32.in_ready), 64'd0);
    step(1'b1, 1'b0, 1'b1, 32'h00300093, 32'd3, 1'b0);
    check_eq("bp.hold_tag", 64'(bus32.out_tag), 64'd1);
    step(1'b1, 1'b0, 1'b1, 32'h00300093, 32'd3, 1'b1);
    check_eq("bp.second_tag", 64'(bus32.out_tag), 64'd2);
    check_eq("bp.rdy3", 64'(bus32.in_ready), 64'd1);
    step(1'b1, 1'b0, 1'b1, 32'h00300093, 32'd3, 1'b1);
    check_eq("bp.third_tag", 64'(bus32.out_tag), 64'd3);
    check_eq("bp.third_imm", 64'(bus32.out_imm), 64'd3);
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

    // Flush while full with a simultaneous offer.
    step(1'b1, 1'b0, 1'b1, 32'h00100093, 32'd4, 1'b0);
    step(1'b1, 1'b0, 1'b1, 32'h00200093, 32'd5, 1'b0);
    step(1'b1, 1'b1, 1'b1, 32'h00700093, 32'd99, 1'b0);
    check_eq("flush.valid", 64'(bus32.out_valid), 64'd0);
    check_eq("flush.rdy", 64'(bus32.in_ready), 64'd1);
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    check_eq("flush.dropped", 64'(bus32.out_valid), 64'd0);

    // Reset while full with a simultaneous offer.
    step(1'b1, 1'b0, 1'b1, 32'h00100093, 32'd6, 1'b0);
    step(1'b1, 1'b0, 1'b1, 32'h00200093, 32'd7, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h00700093, 32'd98, 1'b0);
    check_eq("rst.valid", 64'(bus32.out_valid), 64'd0);
    check_eq("rst.tag", 64'(bus32.out_tag), 64'd0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    check_eq("rst.rdy", 64'(bus32.in_ready), 64'd1);
    check_eq("rst.dropped", 64'(bus32.out_valid), 64'd0);

    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 199) != 0, $urandom_range(0, 49) == 0,
           $urandom_range(0, 9) < 7, rand_inst(), $urandom, $urandom_range(0, 9) < 6);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/imm_gen_stage.md
# imm_gen_stage

Registered, parametrised immediate-generation stage for the pipelined RISC-V core, sitting between instruction fetch/decode and the ID/EX register. It accepts a 32-bit instruction with a pass-through tag (normally the PC), then emits the sign- or zero-extended immediate, a format code and an unknown-opcode flag. The data path is XLEN wide, with optional CSR-zimm and shift-amount formats. A 2-entry skid buffer with valid/ready handshakes lets downstream stall without combinational ready paths.

## Interface
- XLEN, 32, immediate width; legal values are 32 or 64.
- TAG_W, 32, width of the pass-through tag.
- EN_CSR, 1, enables the CSR zimm format.
- EN_SHAMT, 1, enables the shift-amount format.
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- flush  in  1  synchronous pipeline flush.
- in_valid  in  1  input instruction valid.
- in_ready  out  1  stage can accept this cycle.
- in_inst  in  32  instruction word.
- in_tag  in  TAG_W  tag carried alongside the instruction.
- out_valid  out  1  output entry valid.
- out_ready  in  1  downstream accepts this cycle.
- out_imm  out  XLEN  generated immediate.
- out_fmt  out  3  format code: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 CSR, 7 SHAMT.
- out_unknown  out  1  opcode not recognised.
- out_tag  out  TAG_W  tag of the output entry.

## Operation
- Decode is combinational on in_inst. The result is registered on acceptance (in_valid && in_ready).
- Opcode to format mapping:
  - OP-IMM, LOAD, JALR, MISC-MEM → I, sign-extended inst[31:20].
  - STORE → S.
  - BRANCH → B, with bit 0 = 0.
  - LUI, AUIPC → U: {inst[31:12], 12'b0}. For XLEN=64, sign-extended from bit 31.
  - JAL → J, with bit 0 = 0.
  - OP, and OP-32 when XLEN=64 → NONE, imm 0.
- All sign extension replicates inst[31] up to XLEN-1.
- SHAMT format applies when EN_SHAMT=1, on OP-IMM (and OP-IMM-32 when XLEN=64) with funct3 001 or 101:
  - imm = zero-extended shamt: inst[24:20] for XLEN=32 or OP-IMM-32; inst[25:20] for XLEN=64 OP-IMM.
  - funct7 bits are excluded.
  - When EN_SHAMT=0, these instructions use the I format.
- SYSTEM opcode:
  - funct3[2]=1 with EN_CSR=1 → CSR format, imm = zero-extended inst[19:15].
  - All other SYSTEM cases → NONE, imm 0.
- Any other opcode → fmt NONE, imm 0, out_unknown=1. In every other case out_unknown=0.
- Skid buffer: one output register (OUT) plus one skid register (SKD). Order is strictly FIFO.
- States, by number of full entries:
  - EMPTY: accept → ONE.
  - ONE: accept with out_ready → ONE (OUT replaced). Accept without out_ready → TWO (new data to SKD). out_ready without accept → EMPTY.
  - TWO: out_ready → ONE (SKD moves to OUT). No accept is possible in this state.
- in_ready is registered: it is 1 in EMPTY and ONE, and 0 in TWO and during reset.
- Priority: reset, then flush, then handshakes. A flush clears both entries, and any input offered in that cycle is dropped.

## Timing
- Latency is 1 cycle from acceptance to out_valid. Throughput is 1 per cycle while out_ready=1.
- Reset values: out_valid=0, in_ready=0 while rst_n=0, then 1 in the first cycle after release. out_imm=0, out_fmt=0, out_unknown=0, out_tag=0.
- Output holding: out_* stay stable while out_valid && !out_ready.
- Flush: out_valid=0 and in_ready=1 in the cycle after flush. Data register contents are don't-care.
- Reset mid-operation: both entries are lost, identical to flush.
- No combinational path exists from out_ready to in_ready.

## Structure
- Opcode constants are the existing ones in the shared riscv_defs.v. Add to that file:
  - IMM_FMT_* codes;
  - OPCODE_SYSTEM, OPCODE_FENCE, OPCODE_OP_IMM_32, OPCODE_OP_32.
- Sub-module imm_decode is purely combinational (inst → imm, fmt, unknown), parametrised by XLEN, EN_CSR and EN_SHAMT. It is instantiated once, ahead of the registers.
- imm_gen_stage contains only the skid buffer and the control FSM.

## Test plan
- Basic I format: XLEN=32, addi 0xFFF00093 with out_ready=1 → next cycle out_valid=1, imm 0xFFFFFFFF, fmt 1. jal 0x0080006F → imm 0x00000008, fmt 5.
- Backpressure: out_ready=0, three back-to-back valid inputs → first two accepted, in_ready=0 after the second. Raise out_ready → outputs appear in order, and the third is accepted one cycle after the first drains.
- CSR and SHAMT: csrrwi 0x3002D073 → imm 5, fmt 6; with EN_CSR=0 → imm 0, fmt 0. slli 0x00309093 and srai 0x4030D093 → imm 3, fmt 7.
- XLEN=64: lui 0x800000B7 → imm 0xFFFFFFFF80000000, fmt 4. Opcode 0x7F → out_unknown=1, imm 0.
- Flush and reset: flush with state TWO plus a simultaneous in_valid → next cycle out_valid=0, in_ready=1, and the input is never emitted. Repeat with rst_n=0 → same result, with outputs at their reset values.
